booth_mult_seq: RTL and testbench
=================================

Name: booth_mult_seq

Overview:
Parametrised sequential radix-2 Booth multiplier. It is the next-generation integer multiply unit for the datapath, feeding the HI/LO registers. It adds the following over the current fixed unit:
- configurable width
- per-operation signed/unsigned mode
- start/busy/done handshake with operand capture
- abort
- fixed, documented latency

Parameters:
WIDTH, 32, operand width in bits; result is 2*WIDTH bits split into hi/lo.
CNT_W, 6, step-counter width; must satisfy 2^CNT_W > WIDTH+1.

Ports:
clock  in  1  rising-edge clock
reset  in  1  synchronous, active-high reset
start  in  1  request; sampled only in IDLE
is_signed  in  1  1 = two's-complement operands, 0 = unsigned; captured with start
op_a  in  WIDTH  multiplier (scanned by Booth recoding)
op_b  in  WIDTH  multiplicand
abort  in  1  cancels an operation in progress
busy  out  1  high while in RUN
done  out  1  one-cycle pulse, result valid
count  out  CNT_W  Booth steps completed in current/last operation
hi  out  WIDTH  product bits [2*WIDTH-1:WIDTH]
lo  out  WIDTH  product bits [WIDTH-1:0]

Behaviour:
- Reset: clock is `clock`; reset is `reset`, synchronous, active-high.
  - On reset: state=IDLE, busy=0, done=0, count=0, hi=0, lo=0, all internal registers cleared.
  - Reset has priority over every other input, including mid-operation; no done pulse is produced.
- States: IDLE, RUN.
- IDLE, start=1 at edge k:
  - Capture operands extended to E=WIDTH+1 bits: sign-extend if is_signed=1, else zero-extend.
  - Load P = {acc=E'b0, mplr=ext(op_a), q=1'b0}; load mcand = ext(op_b).
  - count<=0, busy<=1, state<=RUN.
- IDLE, start=0: hold. hi/lo keep the last result indefinitely.
- RUN, one Booth step per cycle:
  - {mplr[0],q} = 01: acc' = acc + mcand.
  - {mplr[0],q} = 10: acc' = acc - mcand.
  - 00 or 11: acc' = acc.
  - Then arithmetic right shift of the whole {acc',mplr,q} by 1, replicating acc' MSB.
  - Add/sub and shift form one combined next-state value. The shift must not discard the add/sub result.
  - All arithmetic is E bits, wrap-around, no overflow flag.
  - count<=count+1.
- Completion: on the edge performing step E (count==E-1 before the edge):
  - hi/lo <= low 2*WIDTH bits of the post-step {acc,mplr}.
  - done<=1, busy<=0, count<=E, state<=IDLE.
  - Latency: start edge k -> done high after edge k+E (33 cycles for WIDTH=32).
- done: high for exactly one cycle, cleared on the next edge unless a new completion occurs.
- start while busy: ignored; operands not re-captured.
- start in the cycle done=1: accepted, so back-to-back throughput is one result per E+1 cycles.
- abort=1 in RUN: state<=IDLE, busy<=0, done stays 0, hi/lo unchanged, count<=0.
  - abort in IDLE is ignored.
  - abort and start together in IDLE: start wins.
- Operand inputs are don't-care except at the capture edge.
- Signed×unsigned mixing is not supported; is_signed applies to both operands.

Test Plan:
- WIDTH=32, signed, op_a=0xFFFFFFFD (-3), op_b=7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB; done exactly 33 cycles after start edge, busy high for those 33 cycles.
- op_a=op_b=0xFFFFFFFF:
  - unsigned -> hi=0xFFFFFFFE, lo=0x00000001.
  - signed -> hi=0x00000000, lo=0x00000001.
- Signed 0x80000000×0x80000000 -> hi=0x40000000, lo=0. Unsigned 0x80000000×2 -> hi=1, lo=0. Any operand × 0 -> hi=lo=0.
- Start at step 10 of a run with different operands -> ignored; first result correct. Second start asserted in the done cycle -> accepted; its done arrives 33 cycles later with the correct product.
- Abort at step 15 -> busy=0 next cycle, no done pulse, hi/lo retain prior result.
- Reset at step 20 -> all outputs 0, no done.
- Random regression with WIDTH=8 and WIDTH=32 against a reference model, both modes, including random abort/reset injection.

Source files
------------

// File: rtl/booth_mult_seq.sv
// Sequential radix-2 Booth multiplier: one recoding step per cycle over WIDTH+1 bit
// operands, so signed and unsigned products share the same datapath.
module booth_mult_seq #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             abort,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] count,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int E = WIDTH + 1;
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(E - 1);
    localparam logic [CNT_W-1:0] ALL_STEPS = CNT_W'(E);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t state, state_n;

    logic [E-1:0] acc, mplr, mcand;
    logic         q;
    logic [E-1:0] ext_a, ext_b;
    logic [E-1:0] sum, acc_n, mplr_n;
    logic         q_n;
    logic         load, step, finish, cancel;

    // Handshake: start is sampled only while idle (busy=0), including the cycle
    // done=1; busy stays high for exactly E cycles, then done pulses for one cycle
    // with hi/lo already valid. abort while busy drops the operation silently.

    assign ext_a = {is_signed & op_a[WIDTH-1], op_a};
    assign ext_b = {is_signed & op_b[WIDTH-1], op_b};

    always_comb begin
        sum = acc;
        case ({mplr[0], q})
            2'b01:   sum = acc + mcand;
            2'b10:   sum = acc - mcand;
            default: sum = acc;
        endcase
        // Arithmetic shift of {sum, mplr, q}; the add/sub result feeds the shift.
        acc_n  = {sum[E-1], sum[E-1:1]};
        mplr_n = {sum[0], mplr[E-1:1]};
        q_n    = mplr[0];
    end

    always_comb begin
        state_n = state;
        load    = 1'b0;
        step    = 1'b0;
        finish  = 1'b0;
        cancel  = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    load    = 1'b1;
                    state_n = RUN;
                end
            end
            RUN: begin
                if (abort) begin
                    cancel  = 1'b1;
                    state_n = IDLE;
                end else begin
                    step = 1'b1;
                    if (count == LAST_STEP) begin
                        finish  = 1'b1;
                        state_n = IDLE;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            acc   <= '0;
            mplr  <= '0;
            q     <= 1'b0;
            mcand <= '0;
            count <= '0;
            done  <= 1'b0;
            hi    <= '0;
            lo    <= '0;
        end else begin
            done <= finish;
            if (load) begin
                acc   <= '0;
                mplr  <= ext_a;
                q     <= 1'b0;
                mcand <= ext_b;
                count <= '0;
            end else if (cancel) begin
                count <= '0;
            end else if (step) begin
                acc  <= acc_n;
                mplr <= mplr_n;
                q    <= q_n;
                if (finish) begin
                    count <= ALL_STEPS;
                    hi    <= {acc_n[WIDTH-2:0], mplr_n[WIDTH]};
                    lo    <= mplr_n[WIDTH-1:0];
                end else begin
                    count <= count + CNT_W'(1);
                end
            end
        end
    end

    assign busy = (state == RUN);

endmodule

// File: tb/tb_booth_mult_seq.sv
// Directed bench for booth_mult_seq (WIDTH=32): products, latency, handshake,
// abort and mid-operation reset, checked against hand-computed values.
module tb_booth_mult_seq;

    localparam int WIDTH = 32;
    localparam int CNT_W = 6;
    localparam int LAT   = WIDTH + 1;

    logic             clock;
    logic             reset;
    logic             start;
    logic             is_signed;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             abort;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] count;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    int errors = 0;
    int checks = 0;
    logic [2*WIDTH-1:0] exp_q[$];

    booth_mult_seq #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clock(clock), .reset(reset), .start(start), .is_signed(is_signed),
        .op_a(op_a), .op_b(op_b), .abort(abort), .busy(busy), .done(done),
        .count(count), .hi(hi), .lo(lo)
    );

    // clock / reset block
    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // driver: presents an operation for exactly one edge; returns after that edge
    task automatic start_op(input logic sgn, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        start     = 1'b1;
        is_signed = sgn;
        op_a      = a;
        op_b      = b;
        tick();
        start     = 1'b0;
        op_a      = $urandom;
        op_b      = $urandom;
        is_signed = $urandom_range(0, 1);
    endtask

    // waits for done after a capture edge; inj >= 0 pulses a junk start at that step
    task automatic wait_done(input string tag, input int inj);
        int n = 0;
        int busy_n;
        logic [2*WIDTH-1:0] exp;
        busy_n = busy ? 1 : 0;
        while (!done && n < 60) begin
            if (n == inj) begin
                start = 1'b1;
                op_a  = 32'd9;
                op_b  = 32'd9;
            end else begin
                start = 1'b0;
            end
            tick();
            n++;
            if (busy) busy_n++;
        end
        start = 1'b0;
        check({tag, "_latency"}, n, LAT);
        check({tag, "_busy_cycles"}, busy_n, LAT);
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
        check({tag, "_product"}, {hi, lo}, exp);
        check({tag, "_count"}, count, LAT);
        check({tag, "_busy_at_done"}, busy, 0);
    endtask

    task automatic watch_no_done(input string tag, input int cycles);
        int seen = 0;
        for (int i = 0; i < cycles; i++) begin
            tick();
            if (done) seen++;
        end
        check({tag, "_no_done"}, seen, 0);
    endtask

    logic               v_sgn [9];
    logic [WIDTH-1:0]   v_a   [9];
    logic [WIDTH-1:0]   v_b   [9];
    logic [2*WIDTH-1:0] v_p   [9];

    initial begin
        v_sgn[0] = 1; v_a[0] = 32'hFFFFFFFD; v_b[0] = 32'd7;        v_p[0] = 64'hFFFFFFFF_FFFFFFEB;
        v_sgn[1] = 0; v_a[1] = 32'hFFFFFFFF; v_b[1] = 32'hFFFFFFFF; v_p[1] = 64'hFFFFFFFE_00000001;
        v_sgn[2] = 1; v_a[2] = 32'hFFFFFFFF; v_b[2] = 32'hFFFFFFFF; v_p[2] = 64'h00000000_00000001;
        v_sgn[3] = 1; v_a[3] = 32'h80000000; v_b[3] = 32'h80000000; v_p[3] = 64'h40000000_00000000;
        v_sgn[4] = 0; v_a[4] = 32'h80000000; v_b[4] = 32'd2;        v_p[4] = 64'h00000001_00000000;
        v_sgn[5] = 0; v_a[5] = 32'h12345678; v_b[5] = 32'd0;        v_p[5] = 64'h0;
        v_sgn[6] = 1; v_a[6] = 32'd0;        v_b[6] = 32'hDEADBEEF; v_p[6] = 64'h0;
        v_sgn[7] = 0; v_a[7] = 32'h00010000; v_b[7] = 32'h00010000; v_p[7] = 64'h00000001_00000000;
        v_sgn[8] = 1; v_a[8] = 32'd7;        v_b[8] = 32'hFFFFFFFD; v_p[8] = 64'hFFFFFFFF_FFFFFFEB;

        reset = 1'b1; start = 1'b0; abort = 1'b0; is_signed = 1'b0;
        op_a = '0; op_b = '0;
        tick();
        tick();
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_count", count, 0);
        check("reset_hilo", {hi, lo}, 64'h0);
        reset = 1'b0;
        tick();

        for (int i = 0; i < 9; i++) begin
            exp_q.push_back(v_p[i]);
            start_op(v_sgn[i], v_a[i], v_b[i]);
            check($sformatf("vec%0d_busy_start", i), busy, 1);
            check($sformatf("vec%0d_count_start", i), count, 0);
            wait_done($sformatf("vec%0d", i), -1);
            tick();
            check($sformatf("vec%0d_done_pulse", i), done, 0);
        end

        // junk start at step 10 is ignored, then a start in the done cycle is taken
        exp_q.push_back(64'h1E);
        start_op(1'b0, 32'd5, 32'd6);
        wait_done("ignore_start", 10);
        exp_q.push_back(64'hFFFFFFFF_FFFE7960);
        start_op(1'b1, 32'hFFFFFF9C, 32'd1000);
        check("b2b_busy", busy, 1);
        wait_done("b2b", -1);
        for (int i = 0; i < 5; i++) tick();
        check("idle_hold", {hi, lo}, 64'hFFFFFFFF_FFFE7960);

        // abort at step 15
        start_op(1'b0, 32'd3, 32'd3);
        for (int i = 0; i < 15; i++) tick();
        check("abort_count_pre", count, 15);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_count", count, 0);
        check("abort_hilo", {hi, lo}, 64'hFFFFFFFF_FFFE7960);
        watch_no_done("abort", 40);
        check("abort_hilo_later", {hi, lo}, 64'hFFFFFFFF_FFFE7960);

        // abort together with start in idle: start wins
        abort = 1'b1;
        exp_q.push_back(64'h12340);
        start_op(1'b0, 32'h1234, 32'h10);
        abort = 1'b0;
        check("abort_start_busy", busy, 1);
        wait_done("abort_start", -1);

        // reset at step 20
        start_op(1'b1, 32'd7, 32'd7);
        for (int i = 0; i < 20; i++) tick();
        check("reset_mid_count_pre", count, 20);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("reset_mid_busy", busy, 0);
        check("reset_mid_done", done, 0);
        check("reset_mid_count", count, 0);
        check("reset_mid_hilo", {hi, lo}, 64'h0);
        watch_no_done("reset_mid", 40);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
